// File: rtl/bus_timer_array_if.sv
// Slave-bus bundle for the multi-channel timer: one strobe, one address,
// write data in, combinational read data and wait out.
interface bus_timer_array_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  busEnable;
   logic                  busWrite;
   logic [ADDR_WIDTH-1:0] busAddress;
   logic [31:0]           busWriteData;
   logic [31:0]           busReadData;
   logic                  busWait;

   modport master (
      output busEnable, busWrite, busAddress, busWriteData,
      input  busReadData, busWait
   );

   modport slave (
      input  busEnable, busWrite, busAddress, busWriteData,
      output busReadData, busWait
   );
endinterface

// File: rtl/bus_timer_array.sv
// Bank of 2^CHANNEL_BITS down-counting alarm channels sharing one prescaler,
// each with periodic/one-shot mode, a readable live count and its own interrupt.
module bus_timer_array #(
   parameter int CHANNEL_BITS  = 2,
   parameter int COUNTER_WIDTH = 32,
   parameter int PRESCALE      = 50000
) (
   input  logic                         clock,
   input  logic                         reset,
   bus_timer_array_if.slave             bus,
   output logic [(1<<CHANNEL_BITS)-1:0] interrupt,
   output logic                         interruptAny
);

   localparam int CHANNELS = 1 << CHANNEL_BITS;
   localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      REG_CONTROL  = 2'd0,
      REG_DIVISOR  = 2'd1,
      REG_COUNTER  = 2'd2,
      REG_RESERVED = 2'd3
   } reg_e;

   typedef struct packed {
      logic                     alarm;
      logic                     ie;
      logic                     one_shot;
      logic                     halted;
      logic [COUNTER_WIDTH-1:0] divisor;
      logic [COUNTER_WIDTH-1:0] counter;
   } channel_t;

   logic [PRE_W-1:0]        r_prescaler;
   logic                    w_tick;
   logic [CHANNEL_BITS-1:0] w_channel;
   reg_e                    w_register;
   logic                    w_write;
   logic [31:0]             w_read_data;
   channel_t                r_chan [CHANNELS];
   channel_t                w_chan_next [CHANNELS];

   assign w_tick     = (r_prescaler == PRE_W'(PRESCALE - 1));
   assign w_channel  = bus.busAddress[CHANNEL_BITS+1:2];
   assign w_register = reg_e'(bus.busAddress[1:0]);
   assign w_write    = bus.busEnable & bus.busWrite;

   // Free-running; bus traffic never disturbs the tick phase.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_prescaler <= '0;
      end else if (w_tick) begin
         r_prescaler <= '0;
      end else begin
         r_prescaler <= r_prescaler + 1'b1;
      end
   end

   // A divisor write outranks the tick on the same edge, so a channel being
   // reprogrammed never expires or decrements on that edge. A control write
   // and an expiry on the same edge both land; the expiry's alarm=1 wins.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         // NOTE: every combinational output gets a default before any branch,
         // otherwise an untaken path holds its old value and infers a latch.
         w_chan_next[i] = r_chan[i];

         if (w_write && (w_channel == CHANNEL_BITS'(i)) && (w_register == REG_CONTROL)) begin
            w_chan_next[i].alarm    = bus.busWriteData[0];
            w_chan_next[i].ie       = bus.busWriteData[1];
            w_chan_next[i].one_shot = bus.busWriteData[2];
         end

         if (w_write && (w_channel == CHANNEL_BITS'(i)) && (w_register == REG_DIVISOR)) begin
            w_chan_next[i].divisor = bus.busWriteData[COUNTER_WIDTH-1:0];
            w_chan_next[i].counter = bus.busWriteData[COUNTER_WIDTH-1:0];
            w_chan_next[i].halted  = 1'b0;
         end else if (w_tick && !r_chan[i].halted) begin
            if (r_chan[i].counter == COUNTER_WIDTH'(1)) begin
               w_chan_next[i].alarm   = 1'b1;
               w_chan_next[i].counter = r_chan[i].divisor;
               if (r_chan[i].one_shot) begin
                  w_chan_next[i].halted = 1'b1;
               end
            end else begin
               // Divisor 0 wraps to all ones here, giving 2^COUNTER_WIDTH ticks.
               w_chan_next[i].counter = r_chan[i].counter - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the channel array is a bank of flops, not a RAM, so every
         // entry is reset; divisor and counter come out of reset as all ones.
         for (int i = 0; i < CHANNELS; i++) begin
            r_chan[i]         <= '0;
            r_chan[i].divisor <= '1;
            r_chan[i].counter <= '1;
         end
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // channel samples the same pre-edge values regardless of block order.
         for (int i = 0; i < CHANNELS; i++) begin
            r_chan[i] <= w_chan_next[i];
         end
      end
   end

   always_comb begin
      w_read_data = '0;
      case (w_register)
         REG_CONTROL: w_read_data[3:0] = {r_chan[w_channel].halted,
                                          r_chan[w_channel].one_shot,
                                          r_chan[w_channel].ie,
                                          r_chan[w_channel].alarm};
         REG_DIVISOR: w_read_data = 32'(r_chan[w_channel].divisor);
         REG_COUNTER: w_read_data = 32'(r_chan[w_channel].counter);
         default:     w_read_data = '0;
      endcase
   end

   assign bus.busReadData = w_read_data;
   assign bus.busWait     = 1'b0;

   always_comb begin
      interrupt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         interrupt[i] = r_chan[i].alarm & r_chan[i].ie;
      end
   end

   assign interruptAny = |interrupt;

endmodule

// File: tb/tb_bus_timer_array.sv
// Bench for bus_timer_array: a 32-bit-counter instance for the main features
// and a 4-bit-counter instance for divisor-0 wrap and mid-count reset.
module tb_bus_timer_array;

   localparam int PRESCALE = 4;

   logic       clock = 1'b0;
   logic       reset_a;
   logic       reset_b;
   logic [1:0] intr_a;
   logic [1:0] intr_b;
   logic       any_a;
   logic       any_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } expect_t;

   expect_t sb_q[$];

   // Reference tick model: a tick lands on every PRESCALE-th edge after release.
   int cyc_a, ticks_a, cyc_b, ticks_b;

   always #5 clock = ~clock;

   bus_timer_array_if #(.ADDR_WIDTH(3)) bus_a ();
   bus_timer_array_if #(.ADDR_WIDTH(3)) bus_b ();

   bus_timer_array #(.CHANNEL_BITS(1), .COUNTER_WIDTH(32), .PRESCALE(PRESCALE)) dut_a (
      .clock        (clock),
      .reset        (reset_a),
      .bus          (bus_a),
      .interrupt    (intr_a),
      .interruptAny (any_a)
   );

   bus_timer_array #(.CHANNEL_BITS(1), .COUNTER_WIDTH(4), .PRESCALE(PRESCALE)) dut_b (
      .clock        (clock),
      .reset        (reset_b),
      .bus          (bus_b),
      .interrupt    (intr_b),
      .interruptAny (any_b)
   );

   always @(posedge clock or negedge reset_a) begin
      if (!reset_a) begin
         cyc_a   <= 0;
         ticks_a <= 0;
      end else begin
         cyc_a <= cyc_a + 1;
         if ((cyc_a + 1) % PRESCALE == 0) ticks_a <= ticks_a + 1;
      end
   end

   always @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         cyc_b   <= 0;
         ticks_b <= 0;
      end else begin
         cyc_b <= cyc_b + 1;
         if ((cyc_b + 1) % PRESCALE == 0) ticks_b <= ticks_b + 1;
      end
   end

   task automatic drive(input bit d, input logic en, input logic wr,
                        input logic [2:0] addr, input logic [31:0] data);
      if (!d) begin
         bus_a.busEnable = en; bus_a.busWrite = wr;
         bus_a.busAddress = addr; bus_a.busWriteData = data;
      end else begin
         bus_b.busEnable = en; bus_b.busWrite = wr;
         bus_b.busAddress = addr; bus_b.busWriteData = data;
      end
   endtask

   task automatic bus_write(input bit d, input int ch, input int rg, input logic [31:0] data);
      logic [2:0] addr;
      addr = {ch[0], rg[1:0]};
      drive(d, 1'b1, 1'b1, addr, data);
      @(posedge clock);
      #1 drive(d, 1'b0, 1'b0, addr, 32'h0);
      @(negedge clock);
   endtask

   task automatic read_expect(input bit d, input int ch, input int rg,
                              input logic [31:0] exp, input string name);
      logic [2:0]  addr;
      logic [31:0] got;
      expect_t     e;
      addr   = {ch[0], rg[1:0]};
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
      drive(d, 1'b1, 1'b0, addr, 32'h0);
      #1;
      got = d ? bus_b.busReadData : bus_a.busReadData;
      e   = sb_q.pop_front();
      total++;
      if (got !== e.exp) begin
         bad++;
         $display("FAIL %s: read %h, expected %h", e.name, got, e.exp);
      end
      drive(d, 1'b0, 1'b0, addr, 32'h0);
   endtask

   task automatic wait_ticks(input bit d, input int n);
      int start;
      bit done;
      start = d ? ticks_b : ticks_a;
      done  = 1'b0;
      for (int k = 0; k < (n + 1) * PRESCALE; k++) begin
         @(negedge clock);
         if ((d ? ticks_b : ticks_a) - start >= n) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         bad++;
         $display("FAIL wait_ticks: saw %0d ticks, required %0d", (d ? ticks_b : ticks_a) - start, n);
      end
   endtask

   // Returns at the negedge just before an edge that carries a tick.
   task automatic align_tick(input bit d);
      bit done;
      done = 1'b0;
      for (int k = 0; k <= PRESCALE; k++) begin
         if (((d ? cyc_b : cyc_a) + 1) % PRESCALE == 0) begin
            done = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!done) begin
         bad++;
         $display("FAIL align_tick: tick edge not found, required within %0d cycles", PRESCALE);
      end
   endtask

   task automatic test_reset();
      total++;
      if (intr_a !== 2'b00 || any_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_irq_a: interrupt=%b any=%b, expected 00/0", intr_a, any_a);
      end
      total++;
      if (intr_b !== 2'b00 || bus_a.busWait !== 1'b0) begin
         bad++;
         $display("FAIL reset_irq_b: interrupt=%b wait=%b, expected 00/0", intr_b, bus_a.busWait);
      end
      read_expect(0, 0, 0, 32'h0000_0000, "reset_ch0_ctrl");
      read_expect(0, 1, 0, 32'h0000_0000, "reset_ch1_ctrl");
      read_expect(0, 0, 1, 32'hffff_ffff, "reset_ch0_div");
      read_expect(0, 0, 2, 32'hffff_ffff, "reset_ch0_cnt");
      read_expect(0, 1, 2, 32'hffff_ffff, "reset_ch1_cnt");
      read_expect(0, 0, 3, 32'h0000_0000, "reset_ch0_rsvd");
      read_expect(1, 0, 1, 32'h0000_000f, "reset_b_div");
      read_expect(1, 1, 2, 32'h0000_000f, "reset_b_cnt");
   endtask

   task automatic test_control();
      bus_write(0, 1, 0, 32'hffff_ffff);
      read_expect(0, 1, 0, 32'h0000_0007, "ctrl_all_ones");
      total++;
      if (intr_a !== 2'b10 || any_a !== 1'b1) begin
         bad++;
         $display("FAIL ctrl_irq_set: interrupt=%b any=%b, expected 10/1", intr_a, any_a);
      end
      read_expect(0, 0, 0, 32'h0000_0000, "ctrl_isolation");
      bus_write(0, 1, 0, 32'h0000_0000);
      total++;
      if (intr_a !== 2'b00 || any_a !== 1'b0) begin
         bad++;
         $display("FAIL ctrl_irq_clr: interrupt=%b any=%b, expected 00/0", intr_a, any_a);
      end
      read_expect(0, 1, 0, 32'h0000_0000, "ctrl_cleared");
      bus_write(0, 0, 2, 32'h0000_0055);
      bus_write(0, 0, 3, 32'hffff_ffff);
      read_expect(0, 0, 3, 32'h0000_0000, "rsvd_write_ignored");
      read_expect(0, 0, 2, 32'hffff_ffff - 32'(ticks_a), "cnt_write_ignored");
   endtask

   task automatic test_periodic();
      wait_ticks(0, 1);
      bus_write(0, 0, 1, 32'd3);
      read_expect(0, 0, 2, 32'd3, "per_load_cnt");
      read_expect(0, 0, 1, 32'd3, "per_load_div");
      wait_ticks(0, 2);
      read_expect(0, 0, 2, 32'd1, "per_cnt_after2");
      read_expect(0, 0, 0, 32'h0, "per_no_alarm_yet");
      wait_ticks(0, 1);
      read_expect(0, 0, 0, 32'h1, "per_alarm");
      read_expect(0, 0, 2, 32'd3, "per_reload");
      bus_write(0, 0, 0, 32'h2);
      read_expect(0, 0, 0, 32'h2, "per_alarm_cleared");
      wait_ticks(0, 2);
      total++;
      if (intr_a[0] !== 1'b0) begin
         bad++;
         $display("FAIL per_irq_early: interrupt[0]=%b, expected 0", intr_a[0]);
      end
      wait_ticks(0, 1);
      total++;
      if (intr_a[0] !== 1'b1 || any_a !== 1'b1) begin
         bad++;
         $display("FAIL per_irq_again: interrupt[0]=%b any=%b, expected 1/1", intr_a[0], any_a);
      end
      read_expect(0, 1, 2, 32'hffff_ffff - 32'(ticks_a), "per_ch1_untouched");
   endtask

   task automatic test_one_shot();
      wait_ticks(0, 1);
      bus_write(0, 1, 0, 32'h6);
      bus_write(0, 1, 1, 32'd2);
      read_expect(0, 1, 2, 32'd2, "os_load");
      wait_ticks(0, 1);
      read_expect(0, 1, 2, 32'd1, "os_cnt1");
      read_expect(0, 1, 0, 32'h6, "os_ctrl_running");
      wait_ticks(0, 1);
      read_expect(0, 1, 0, 32'hf, "os_halted");
      read_expect(0, 1, 2, 32'd2, "os_reload");
      total++;
      if (intr_a[1] !== 1'b1) begin
         bad++;
         $display("FAIL os_irq: interrupt[1]=%b, expected 1", intr_a[1]);
      end
      wait_ticks(0, 20);
      read_expect(0, 1, 2, 32'd2, "os_holds");
      read_expect(0, 1, 0, 32'hf, "os_still_halted");
      bus_write(0, 1, 0, 32'h2);
      wait_ticks(0, 3);
      read_expect(0, 1, 0, 32'ha, "os_clear_no_restart");
      read_expect(0, 1, 2, 32'd2, "os_clear_holds");
      wait_ticks(0, 1);
      bus_write(0, 1, 0, 32'h6);
      bus_write(0, 1, 1, 32'd2);
      read_expect(0, 1, 0, 32'h6, "os_restart");
      wait_ticks(0, 1);
      read_expect(0, 1, 2, 32'd1, "os_restart_cnt");
      wait_ticks(0, 1);
      read_expect(0, 1, 0, 32'hf, "os_second_alarm");
      bus_write(0, 1, 0, 32'h0);
   endtask

   task automatic test_back_to_back();
      wait_ticks(0, 1);
      bus_write(0, 0, 0, 32'h2);
      for (int i = 0; i < 5; i++) begin
         align_tick(0);
         bus_write(0, 0, 1, 32'd2);
         read_expect(0, 0, 2, 32'd2, "b2b_write_wins");
         read_expect(0, 0, 0, 32'h2, "b2b_no_alarm");
      end
      wait_ticks(0, 1);
      read_expect(0, 0, 2, 32'd1, "b2b_resume_cnt");
      wait_ticks(0, 1);
      read_expect(0, 0, 0, 32'h3, "b2b_alarm");
      total++;
      if (intr_a[0] !== 1'b1) begin
         bad++;
         $display("FAIL b2b_irq: interrupt[0]=%b, expected 1", intr_a[0]);
      end
   endtask

   task automatic test_wrap_and_reset();
      wait_ticks(1, 1);
      bus_write(1, 0, 0, 32'h2);
      bus_write(1, 0, 1, 32'h0);
      read_expect(1, 0, 1, 32'h0, "wrap_div0");
      wait_ticks(1, 15);
      read_expect(1, 0, 2, 32'd1, "wrap_cnt15");
      total++;
      if (intr_b !== 2'b00) begin
         bad++;
         $display("FAIL wrap_irq_early: interrupt=%b, expected 00", intr_b);
      end
      wait_ticks(1, 1);
      read_expect(1, 0, 0, 32'h3, "wrap_alarm16");
      read_expect(1, 0, 2, 32'd0, "wrap_reload0");
      wait_ticks(1, 5);
      read_expect(1, 0, 2, 32'd11, "wrap_midcount");
      bus_write(1, 1, 0, 32'h7);
      total++;
      if (intr_b !== 2'b11 || any_b !== 1'b1) begin
         bad++;
         $display("FAIL prereset_irq: interrupt=%b any=%b, expected 11/1", intr_b, any_b);
      end
      #2 reset_b = 1'b0;
      #1;
      total++;
      if (intr_b !== 2'b00 || any_b !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_irq: interrupt=%b any=%b, expected 00/0", intr_b, any_b);
      end
      read_expect(1, 0, 0, 32'h0, "async_reset_ctrl0");
      read_expect(1, 1, 0, 32'h0, "async_reset_ctrl1");
      read_expect(1, 0, 1, 32'hf, "async_reset_div");
      read_expect(1, 0, 2, 32'hf, "async_reset_cnt");
      @(negedge clock);
      reset_b = 1'b1;
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 3'd0, 32'h0);
      drive(1, 1'b0, 1'b0, 3'd0, 32'h0);
      reset_a = 1'b0;
      reset_b = 1'b0;
      repeat (2) @(negedge clock);
      test_reset();
      @(negedge clock);
      reset_a = 1'b1;
      reset_b = 1'b1;
      test_control();
      test_periodic();
      test_one_shot();
      test_back_to_back();
      test_wrap_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bus_timer_array.md
Name: bus_timer_array

Overview:
- Multi-channel successor of the single-channel bus timer: 2^CHANNEL_BITS independent down-counting alarm channels.
- All channels share one free-running prescaler.
- Each channel adds periodic/one-shot mode and a readable live count.
- Sits on the slave bus like the existing timer. Drives one interrupt line per channel plus an OR-combined line to the interrupt controller.

Parameters:
CHANNEL_BITS, 2, log2 of channel count (CHANNELS = 2^CHANNEL_BITS, 1..8 bits).
COUNTER_WIDTH, 32, width of divisor and counter per channel (1..32).
PRESCALE, 50000, clock cycles per tick (>=2); 50000 gives 1 ms at 50 MHz.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
busEnable  input  1  bus access strobe.
busWrite  input  1  1 = write, 0 = read.
busAddress  input  CHANNEL_BITS+2  {channel, register}; register = busAddress[1:0].
busWriteData  input  32  write data.
busReadData  output  32  read data, combinational, zero-extended.
busWait  output  1  constant 0 (zero wait states).
interrupt  output  CHANNELS  per-channel interrupt, interrupt[i] = alarm[i] & ie[i].
interruptAny  output  1  OR of interrupt.

Behaviour:
- Reset (reset low, asynchronous):
  - prescaler = 0.
  - Per channel: alarm = 0, ie = 0, oneShot = 0, halted = 0, divisor = all ones, counter = all ones.
  - All outputs 0.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick is asserted for one cycle when prescaler == PRESCALE-1.
  - The prescaler is never reset by bus writes.
- Register map per channel (reg = busAddress[1:0]):
  - 0 control, R/W:
    - bit0 alarm
    - bit1 ie
    - bit2 oneShot
    - bit3 halted (read-only)
    - Other bits are ignored on write and read as 0.
    - Writing the alarm bit sets it to the written value.
  - 1 divisor, R/W: low COUNTER_WIDTH bits. A write also sets counter = data and halted = 0.
  - 2 counter, R only: live count. Writes are ignored.
  - 3 reserved: reads 0, writes ignored.
- Writes take effect at the clock edge where busEnable & busWrite. A read returns the current register value in the same cycle.
- Per channel, on tick when halted = 0:
  - counter == 1: expiry. Set alarm = 1 and counter = divisor. If oneShot = 1, also set halted = 1.
  - Otherwise: counter = counter - 1, modulo 2^COUNTER_WIDTH. As a result, divisor 0 expires after 2^COUNTER_WIDTH ticks.
- When halted = 1, the counter holds and ticks are ignored. Only a divisor write restarts the channel.
- Clearing oneShot while halted does not restart the channel.
- Simultaneous events, same channel, same edge:
  - Divisor write + tick: the write wins. counter = data; the tick is ignored for that channel, including any expiry.
  - Control write + expiry: the expiry sets alarm = 1 and halted as above. ie and oneShot take the written values.
  - Writes to one channel never affect another channel.
- Interrupts are combinational from register state. No latency beyond the register update.
- Reset asserted mid-count returns everything to reset values immediately.

Test Plan:
1. Reset, CHANNEL_BITS=1, COUNTER_WIDTH=32, PRESCALE=4 -> interrupt=2'b00; ch0 and ch1 control read 0; divisor reads 32'hffffffff; counter reads 32'hffffffff.
2. Write ch1 control=32'hffffffff -> reads 32'h00000007 (halted RO = 0); interrupt=2'b10, interruptAny=1. Write ch1 control=0 -> interrupt=2'b00.
3. Write ch0 divisor=3 (periodic) -> alarm=0 while ≤2 ticks (≤8 cycles) have elapsed; alarm=1 after 3 ticks (≤12 cycles); counter reads 3 after expiry. Clear alarm -> alarm=1 again after 3 more ticks. ch1 counter is unaffected.
4. ch1 oneShot=1, divisor=2 -> after 2 ticks: alarm=1, halted=1, counter holds 2 for 20 further ticks. Rewrite divisor=2 -> halted=0; alarm recurs 2 ticks later.
5. Rewrite ch0 divisor=2 every tick for 5 ticks -> no alarm. Stop rewriting -> alarm within 2 ticks.
6. COUNTER_WIDTH=4, divisor=0 -> no alarm after 15 ticks; alarm at tick 16. Assert reset mid-count -> all state returns to reset values asynchronously.
